// File: rtl/rom_dl_if.sv
// HPS download bus between the ioctl source and the ROM download controller.
// ioctl_wr is a one-cycle byte strobe. ioctl_wait=1 means the controller is busy and any ioctl_wr seen then is dropped.
// dn_wr is held for a fixed number of cycles, with dn_addr and dn_data stable for the whole strobe.
interface rom_dl_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
        input  ioctl_wait, dn_addr, dn_data, dn_wr
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
        output ioctl_wait, dn_addr, dn_data, dn_wr
    );
endinterface

// File: rtl/rom_dl_ctrl.sv
// ROM download controller: turns HPS ioctl bytes into stretched ROM writes, holds the core in reset, and latches mod/DIP bytes.
// Define DL_CHECKSUM_EN to add the chk_sum output (modulo-256 sum of the accepted ROM bytes).
module rom_dl_ctrl #(
    parameter int          DN_WR_LEN = 4,
    parameter int          POST_RST  = 1024,
    parameter logic [15:0] ROM_LIMIT = 16'hF000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    rom_dl_if.slave    bus,
    output logic       core_reset,
    output logic [7:0] mod,
    output logic [7:0] sw0,
    output logic [7:0] sw1,
    output logic [7:0] sw2,
    output logic       rom_valid,
`ifdef DL_CHECKSUM_EN
    output logic [7:0] chk_sum,
`endif
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DRAIN = 3'd3,
        S_POST  = 3'd4,
        S_RUN   = 3'd5
    } state_t;

    localparam logic [15:0] WR_CNT   = 16'(DN_WR_LEN - 1);
    localparam logic [15:0] POST_CNT = 16'(POST_RST - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_dl_fell;
    logic        r_wait;
    logic        r_dn_wr;
    logic [15:0] r_dn_addr;
    logic [7:0]  r_dn_data;
    logic        r_core_reset;
    logic        r_rom_valid;
    logic [7:0]  r_mod;
    logic [7:0]  r_sw0;
    logic [7:0]  r_sw1;
    logic [7:0]  r_sw2;

    // Strobes arriving while the HPS is being held off are discarded.
    logic w_wr_ok;
    logic w_enter_load;
    logic w_rom_byte;
    logic w_accept;

    assign w_wr_ok      = bus.ioctl_wr && !r_wait;
    assign w_enter_load = ((r_state == S_IDLE) || (r_state == S_RUN)) &&
                          bus.ioctl_download && (bus.ioctl_index == 8'd0);
    assign w_rom_byte   = w_wr_ok && (bus.ioctl_index == 8'd0) &&
                          (bus.ioctl_addr[24:16] == 9'd0) && (bus.ioctl_addr[15:0] < ROM_LIMIT);
    assign w_accept     = (r_state == S_LOAD) && bus.ioctl_download && w_rom_byte;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_dl_fell    <= 1'b0;
            r_wait       <= 1'b0;
            r_dn_wr      <= 1'b0;
            r_dn_addr    <= '0;
            r_dn_data    <= '0;
            r_core_reset <= 1'b1;
            r_rom_valid  <= 1'b0;
            r_mod        <= '0;
            r_sw0        <= '0;
            r_sw1        <= '0;
            r_sw2        <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (w_enter_load) begin
                        r_state      <= S_LOAD;
                        r_rom_valid  <= 1'b0;
                        r_core_reset <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!bus.ioctl_download) begin
                        r_state <= S_POST;
                        r_cnt   <= POST_CNT;
                    end else if (w_accept) begin
                        r_state   <= S_WRITE;
                        r_dn_addr <= bus.ioctl_addr[15:0];
                        r_dn_data <= bus.ioctl_dout;
                        r_dn_wr   <= 1'b1;
                        r_wait    <= 1'b1;
                        r_cnt     <= WR_CNT;
                        r_dl_fell <= 1'b0;
                    end
                end
                S_WRITE: begin
                    // A download that ends mid-strobe is remembered so the write still completes.
                    if (!bus.ioctl_download) r_dl_fell <= 1'b1;
                    if (r_cnt == 16'd0) begin
                        r_dn_wr <= 1'b0;
                        r_wait  <= 1'b0;
                        r_state <= (!bus.ioctl_download || r_dl_fell) ? S_DRAIN : S_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_POST;
                    r_cnt   <= POST_CNT;
                end
                S_POST: begin
                    if (r_cnt == 16'd0) begin
                        r_state      <= S_RUN;
                        r_rom_valid  <= 1'b1;
                        r_core_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_wr_ok && (bus.ioctl_index == 8'd1)) r_mod <= bus.ioctl_dout;

            if (w_wr_ok && (bus.ioctl_index == 8'd254) && (bus.ioctl_addr[24:3] == 22'd0)) begin
                case (bus.ioctl_addr[2:0])
                    3'd0:    r_sw0 <= bus.ioctl_dout;
                    3'd1:    r_sw1 <= bus.ioctl_dout;
                    3'd2:    r_sw2 <= bus.ioctl_dout;
                    default: ;
                endcase
            end
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [7:0] r_chk;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)          r_chk <= '0;
        else if (w_enter_load) r_chk <= '0;
        else if (w_accept)     r_chk <= r_chk + bus.ioctl_dout;
    end

    assign chk_sum = r_chk;
`endif

    assign bus.ioctl_wait = r_wait;
    assign bus.dn_wr      = r_dn_wr;
    assign bus.dn_addr    = r_dn_addr;
    assign bus.dn_data    = r_dn_data;
    assign core_reset     = r_core_reset;
    assign rom_valid      = r_rom_valid;
    assign mod            = r_mod;
    assign sw0            = r_sw0;
    assign sw1            = r_sw1;
    assign sw2            = r_sw2;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Bench for rom_dl_ctrl at default parameters: ROM byte table, side-band table, and hand-written drain/reset sequences.
module tb_rom_dl_ctrl;
    logic clk_sys = 1'b0;
    logic reset_n;
    always #5 clk_sys = ~clk_sys;

    rom_dl_if bus ();

    logic       core_reset;
    logic       rom_valid;
    logic [7:0] mod, sw0, sw1, sw2;
    logic [2:0] dbg_state;
`ifdef DL_CHECKSUM_EN
    logic [7:0] chk_sum;
`endif

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_POST  = 3'd4;
    localparam logic [2:0] ST_RUN   = 3'd5;

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] exp_q[$];
    logic prev_dn_wr = 1'b0;

    rom_dl_ctrl dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .bus        (bus),
        .core_reset (core_reset),
        .mod        (mod),
        .sw0        (sw0),
        .sw1        (sw1),
        .sw2        (sw2),
        .rom_valid  (rom_valid),
`ifdef DL_CHECKSUM_EN
        .chk_sum    (chk_sum),
`endif
        .o_dbg_state(dbg_state)
    );

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        accept;
    } rom_vec_t;

    typedef struct {
        logic [7:0]  index;
        logic [24:0] addr;
        logic [7:0]  data;
        logic [7:0]  e_mod;
        logic [7:0]  e_sw0;
        logic [7:0]  e_sw1;
        logic [7:0]  e_sw2;
    } side_vec_t;

    rom_vec_t  rom_tab[6];
    side_vec_t side_tab[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every rising dn_wr must match the next expected {addr, data}.
    always @(negedge clk_sys) begin
        if (bus.dn_wr && !prev_dn_wr) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_dn_wr", 32'(bus.dn_addr), 32'hFFFF_FFFF);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                chk("sb_write", 32'({bus.dn_addr, bus.dn_data}), 32'(e));
            end
        end
        prev_dn_wr = bus.dn_wr;
    end

    // All tasks start and end just after a falling edge.
    task automatic send_byte(input logic [7:0] idx, input logic [24:0] addr,
                             input logic [7:0] data, input logic push);
        bus.ioctl_wr    = 1'b1;
        bus.ioctl_index = idx;
        bus.ioctl_addr  = addr;
        bus.ioctl_dout  = data;
        if (push) exp_q.push_back({addr[15:0], data});
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic check_strobe(input logic [15:0] e_addr, input logic [7:0] e_data);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("strobe_dn_wr_c%0d", i), 32'(bus.dn_wr), 32'd1);
            chk($sformatf("strobe_wait_c%0d", i), 32'(bus.ioctl_wait), 32'd1);
            chk($sformatf("strobe_addr_c%0d", i), 32'(bus.dn_addr), 32'(e_addr));
            chk($sformatf("strobe_data_c%0d", i), 32'(bus.dn_data), 32'(e_data));
            @(negedge clk_sys);
        end
        chk("strobe_end_dn_wr", 32'(bus.dn_wr), 32'd0);
        chk("strobe_end_wait", 32'(bus.ioctl_wait), 32'd0);
        chk("strobe_end_state", 32'(dbg_state), 32'(ST_LOAD));
    endtask

    task automatic check_dropped();
        for (int i = 0; i < 3; i++) begin
            chk("drop_dn_wr", 32'(bus.dn_wr), 32'd0);
            chk("drop_wait", 32'(bus.ioctl_wait), 32'd0);
            chk("drop_state", 32'(dbg_state), 32'(ST_LOAD));
            @(negedge clk_sys);
        end
    endtask

    task automatic start_download();
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 8'd0;
        @(negedge clk_sys);
        chk("dl_start_state", 32'(dbg_state), 32'(ST_LOAD));
        chk("dl_start_core_reset", 32'(core_reset), 32'd1);
        chk("dl_start_rom_valid", 32'(rom_valid), 32'd0);
    endtask

    task automatic wait_run(input int exp_cycles);
        int c;
        c = 0;
        while (c < 2000) begin
            @(negedge clk_sys);
            c++;
            if (core_reset == 1'b0) break;
        end
        chk("post_reset_cycles", 32'(c), 32'(exp_cycles));
        chk("run_state", 32'(dbg_state), 32'(ST_RUN));
        chk("run_rom_valid", 32'(rom_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: actual timeout required finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rom_tab[0] = '{25'h0_0000, 8'h11, 1'b1};
        rom_tab[1] = '{25'h0_0001, 8'h22, 1'b1};
        rom_tab[2] = '{25'h0_0002, 8'h33, 1'b1};
        rom_tab[3] = '{25'h0_F000, 8'h44, 1'b0};
        rom_tab[4] = '{25'h1_0000, 8'h55, 1'b0};
        rom_tab[5] = '{25'h0_EFFF, 8'h5A, 1'b1};

        side_tab[0] = '{8'd1,   25'd0, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00};
        side_tab[1] = '{8'd254, 25'd1, 8'hA5, 8'h02, 8'h00, 8'hA5, 8'h00};
        side_tab[2] = '{8'd254, 25'd0, 8'h3C, 8'h02, 8'h3C, 8'hA5, 8'h00};
        side_tab[3] = '{8'd254, 25'd2, 8'hC3, 8'h02, 8'h3C, 8'hA5, 8'hC3};
        side_tab[4] = '{8'd254, 25'd3, 8'hFF, 8'h02, 8'h3C, 8'hA5, 8'hC3};
        side_tab[5] = '{8'd254, 25'd8, 8'h99, 8'h02, 8'h3C, 8'hA5, 8'hC3};
        side_tab[6] = '{8'd1,   25'd5, 8'h07, 8'h07, 8'h3C, 8'hA5, 8'hC3};

        reset_n            = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = 8'd0;
        repeat (3) @(negedge clk_sys);

        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_wait", 32'(bus.ioctl_wait), 32'd0);
        chk("rst_dn_wr", 32'(bus.dn_wr), 32'd0);
        chk("rst_dn_addr", 32'(bus.dn_addr), 32'd0);
        chk("rst_dn_data", 32'(bus.dn_data), 32'd0);
        chk("rst_rom_valid", 32'(rom_valid), 32'd0);
        chk("rst_mod", 32'(mod), 32'd0);
        chk("rst_sw", 32'({sw0, sw1, sw2}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        chk("idle_after_reset", 32'(dbg_state), 32'(ST_IDLE));

        // Download 1: three bytes, then the post-download reset window.
        start_download();
        for (int i = 0; i < 3; i++) begin
            send_byte(8'd0, rom_tab[i].addr, rom_tab[i].data, rom_tab[i].accept);
            check_strobe(rom_tab[i].addr[15:0], rom_tab[i].data);
        end
        bus.ioctl_download = 1'b0;
        wait_run(1025);
`ifdef DL_CHECKSUM_EN
        chk("chk_sum_dl1", 32'(chk_sum), 32'h66);
`endif

        // Side-band streams while running.
        for (int i = 0; i < 7; i++) begin
            send_byte(side_tab[i].index, side_tab[i].addr, side_tab[i].data, 1'b0);
            chk($sformatf("side%0d_mod", i), 32'(mod), 32'(side_tab[i].e_mod));
            chk($sformatf("side%0d_sw0", i), 32'(sw0), 32'(side_tab[i].e_sw0));
            chk($sformatf("side%0d_sw1", i), 32'(sw1), 32'(side_tab[i].e_sw1));
            chk($sformatf("side%0d_sw2", i), 32'(sw2), 32'(side_tab[i].e_sw2));
            chk($sformatf("side%0d_core_reset", i), 32'(core_reset), 32'd0);
            chk($sformatf("side%0d_state", i), 32'(dbg_state), 32'(ST_RUN));
        end

        // Download 2: out-of-range bytes are dropped, the last in-range address is kept.
        start_download();
        for (int i = 3; i < 6; i++) begin
            send_byte(8'd0, rom_tab[i].addr, rom_tab[i].data, rom_tab[i].accept);
            if (rom_tab[i].accept) check_strobe(rom_tab[i].addr[15:0], rom_tab[i].data);
            else check_dropped();
        end
        bus.ioctl_download = 1'b0;
        wait_run(1025);
`ifdef DL_CHECKSUM_EN
        chk("chk_sum_dl2", 32'(chk_sum), 32'h5A);
`endif

        // Download ends on the second WRITE cycle: strobe completes, then DRAIN, then POST.
        start_download();
        send_byte(8'd0, 25'd3, 8'h77, 1'b1);
        chk("drain_c0_dn_wr", 32'(bus.dn_wr), 32'd1);
        bus.ioctl_download = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk_sys);
            chk($sformatf("drain_c%0d_dn_wr", i), 32'(bus.dn_wr), 32'd1);
            chk($sformatf("drain_c%0d_wait", i), 32'(bus.ioctl_wait), 32'd1);
            chk($sformatf("drain_c%0d_state", i), 32'(dbg_state), 32'(ST_WRITE));
        end
        @(negedge clk_sys);
        chk("drain_end_dn_wr", 32'(bus.dn_wr), 32'd0);
        chk("drain_state", 32'(dbg_state), 32'(ST_DRAIN));
        @(negedge clk_sys);
        chk("drain_post_state", 32'(dbg_state), 32'(ST_POST));
        chk("drain_post_core_reset", 32'(core_reset), 32'd1);
        wait_run(1024);
`ifdef DL_CHECKSUM_EN
        chk("chk_sum_dl3", 32'(chk_sum), 32'h77);
`endif

        // Reset pulsed mid-WRITE aborts the strobe without waiting for a clock edge.
        start_download();
        send_byte(8'd0, 25'd4, 8'h88, 1'b1);
        chk("abort_pre_dn_wr", 32'(bus.dn_wr), 32'd1);
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_dn_wr", 32'(bus.dn_wr), 32'd0);
        chk("abort_wait", 32'(bus.ioctl_wait), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("abort_core_reset", 32'(core_reset), 32'd1);
        chk("abort_rom_valid", 32'(rom_valid), 32'd0);
        chk("abort_mod", 32'(mod), 32'd0);
        chk("abort_sw1", 32'(sw1), 32'd0);
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        chk("release_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("release_core_reset", 32'(core_reset), 32'd1);
        chk("release_dn_wr", 32'(bus.dn_wr), 32'd0);

        chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_dl_ctrl.md
ROM_DL_CTRL -- requirements
Module: rom_dl_ctrl

Interface
REQ-001 SHALL have parameter DN_WR_LEN, default 4: clk_sys cycles each ROM write strobe is held (range 1..15).
REQ-002 SHALL have parameter POST_RST, default 1024: clk_sys cycles core_reset stays high after a ROM download ends (range 1..65535).
REQ-003 SHALL have parameter ROM_LIMIT, default 16'hF000: first ROM address that is discarded.
REQ-004 SHALL have port clk_sys, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port ioctl_download, input, 1: HPS download in progress.
REQ-007 SHALL have port ioctl_wr, input, 1: one-cycle byte-valid strobe.
REQ-008 SHALL have port ioctl_index, input, 8: stream select (0 ROM, 1 mod byte, 254 DIP).
REQ-009 SHALL have port ioctl_addr, input, 25: byte address.
REQ-010 SHALL have port ioctl_dout, input, 8: byte data.
REQ-011 SHALL have port ioctl_wait, output, 1: back-pressure to the HPS.
REQ-012 SHALL have port dn_addr, output, 16: ROM write address.
REQ-013 SHALL have port dn_data, output, 8: ROM write data.
REQ-014 SHALL have port dn_wr, output, 1: ROM write strobe.
REQ-015 SHALL have port core_reset, output, 1: active-high reset for the game core.
REQ-016 SHALL have port mod, output, 8: game-variant byte.
REQ-017 SHALL have ports sw0, sw1 and sw2, output, 8 each: DIP bytes 0 to 2.
REQ-018 SHALL have port rom_valid, output, 1: high once a ROM load has completed.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, WRITE, DRAIN, POST and RUN.
REQ-020 IDLE/RUN -> LOAD SHALL occur when ioctl_download=1 and ioctl_index=0; in that transition rom_valid SHALL be cleared.
REQ-021 In LOAD, ioctl_wr with ioctl_addr<ROM_LIMIT (bits 24:16 zero) SHALL latch addr[15:0] and data and go to WRITE.
REQ-021 (cont.) In the same cycle ioctl_wait SHALL be asserted.
REQ-022 In LOAD, a byte at address >= ROM_LIMIT SHALL be dropped, produce no dn_wr and leave the FSM in LOAD.
REQ-023 In WRITE, dn_wr=1 and ioctl_wait=1 SHALL hold for exactly DN_WR_LEN cycles, with dn_addr and dn_data stable throughout.
REQ-023 (cont.) After those cycles, the FSM SHALL return to LOAD, or go to DRAIN if ioctl_download has already fallen.
REQ-024 A fall of ioctl_download while in WRITE SHALL NOT truncate the strobe; the write SHALL complete first.
REQ-025 LOAD -> POST SHALL occur on ioctl_download=0; DRAIN -> POST SHALL occur unconditionally after one cycle.
REQ-026 In POST, core_reset SHALL hold for POST_RST cycles, then the FSM SHALL go to RUN and set rom_valid=1.
REQ-027 core_reset SHALL be 1 in every state except RUN, and in RUN it SHALL be 0.
REQ-028 An ioctl_wr with ioctl_index=1 SHALL load mod<=ioctl_dout in the same cycle, in any state and with no wait.
REQ-029 An ioctl_wr with ioctl_index=254 and addr[24:3]=0 SHALL write the DIP register selected by addr[2:0]; only indices 0 to 2 are exported.
REQ-030 Streams with index 1 or 254 SHALL NOT change FSM state or core_reset.
REQ-031 ioctl_wait SHALL be 0 outside WRITE; ioctl_wr pulses arriving while ioctl_wait=1 are a protocol error and SHALL be ignored.
REQ-032 dn_wr SHALL rise at most one cycle after an accepted ioctl_wr.

Reset
REQ-033 While reset_n=0, the FSM SHALL be in IDLE with core_reset=1, ioctl_wait=0, dn_wr=0, dn_addr=0, dn_data=0 and rom_valid=0.
REQ-033 (cont.) mod, sw0, sw1 and sw2 SHALL be 0, and all counters SHALL be 0.
REQ-034 A reset asserted mid-WRITE SHALL abort the strobe immediately and asynchronously; after release the FSM SHALL start in IDLE.

Configuration
REQ-035 With DL_CHECKSUM_EN defined, the block SHALL add output chk_sum, 8 bits: the modulo-256 sum of every accepted ROM byte.
REQ-035 (cont.) chk_sum SHALL be cleared on entry to LOAD and frozen from POST onward.
REQ-036 Without DL_CHECKSUM_EN, chk_sum and its adder SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 Index 0, 3 bytes at addr 0..2 (0x11, 0x22, 0x33) -> three 4-cycle dn_wr pulses at dn_addr 0, 1, 2 with matching data, ioctl_wait high during each.
REQ-037 (cont.) Then 1024 cycles of core_reset, then rom_valid=1 and core_reset=0; chk_sum=0x66 when DL_CHECKSUM_EN is defined.
REQ-038 Byte at addr 0xF000 and addr 0x10000 -> no dn_wr and ioctl_wait stays 0.
REQ-039 ioctl_download falls on the 2nd cycle of WRITE -> the full 4-cycle strobe completes, then DRAIN, then POST.
REQ-040 Index 1 data 0x02 in RUN -> mod=0x02; index 254 addr 1 data 0xA5 -> sw1=0xA5; core_reset stays 0 for both.
REQ-041 reset_n pulsed low mid-WRITE -> dn_wr=0 and ioctl_wait=0 asynchronously, and IDLE with core_reset=1 after release.
